// File: rtl/countdown_ctrl.sv
// Game countdown timer: one-second prescaler, remaining-seconds register and IDLE/RUN/PAUSED/DONE FSM.
// Latency: commands act on the sampling edge and are visible one cycle later; no backpressure, commands are level-sampled.
module countdown_ctrl #(
    parameter int DIV     = 100000000,
    parameter int MAX_SEC = 99
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [6:0] load_sec,
    input  logic       start,
    input  logic       pause,
    input  logic       abort,
    output logic [6:0] remaining,
    output logic       tick,
    output logic       done,
    output logic       busy,
    output logic [1:0] state
);

    localparam int PW = $clog2(DIV);
    localparam logic [PW-1:0] PS_LAST = PW'(DIV - 1);
    localparam logic [6:0]    MAX_V   = 7'(MAX_SEC);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t        st, st_n;
    logic [PW-1:0] ps, ps_n;
    logic [6:0]    rem, rem_n;
    logic          tick_n, done_n;
    logic [6:0]    load_sat;

    assign load_sat = (load_sec > MAX_V) ? MAX_V : load_sec;

    always_ff @(posedge clk) begin
        if (rst) begin
            st   <= IDLE;
            ps   <= '0;
            rem  <= '0;
            tick <= 1'b0;
            done <= 1'b0;
            busy <= 1'b0;
        end else begin
            st   <= st_n;
            ps   <= ps_n;
            rem  <= rem_n;
            tick <= tick_n;
            done <= done_n;
            busy <= (st_n == RUN);
        end
    end

    // Commands in priority order; an illegal command falls through to the next one.
    always_comb begin
        st_n   = st;
        ps_n   = ps;
        rem_n  = rem;
        tick_n = 1'b0;
        done_n = 1'b0;
        if (abort) begin
            st_n  = IDLE;
            rem_n = '0;
            ps_n  = '0;
        end else if (load && st != RUN) begin
            st_n  = IDLE;
            rem_n = load_sat;
            ps_n  = '0;
        end else if (pause && st == RUN) begin
            st_n = PAUSED;
        end else if (start && ((st == IDLE && rem != 7'd0) || st == PAUSED)) begin
            st_n = RUN;
            ps_n = (st == IDLE) ? '0 : ps;
        end else if (st == RUN) begin
            if (ps == PS_LAST) begin
                ps_n   = '0;
                tick_n = 1'b1;
                if (rem != 7'd0) begin
                    rem_n = rem - 7'd1;
                end
                if (rem == 7'd1) begin
                    done_n = 1'b1;
                    st_n   = DONE;
                end
            end else begin
                ps_n = ps + PW'(1);
            end
        end
    end

    assign remaining = rem;
    assign state     = st;

endmodule

// File: tb/tb_countdown_ctrl.sv
// Directed bench for countdown_ctrl with DIV=4; inputs change and outputs are sampled on the falling edge.
module tb_countdown_ctrl;

    logic       clk;
    logic       rst;
    logic       load;
    logic [6:0] load_sec;
    logic       start;
    logic       pause;
    logic       abort;
    logic [6:0] remaining;
    logic       tick;
    logic       done;
    logic       busy;
    logic [1:0] state;

    int n_checks = 0;
    int n_fail   = 0;

    countdown_ctrl #(.DIV(4), .MAX_SEC(99)) dut (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .load_sec  (load_sec),
        .start     (start),
        .pause     (pause),
        .abort     (abort),
        .remaining (remaining),
        .tick      (tick),
        .done      (done),
        .busy      (busy),
        .state     (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Apply one command cycle: {abort, load, pause, start} with load_sec.
    task automatic cmd(input logic a, input logic l, input logic p, input logic s,
                       input logic [6:0] ls);
        abort = a; load = l; pause = p; start = s; load_sec = ls;
        step();
        abort = 1'b0; load = 1'b0; pause = 1'b0; start = 1'b0;
    endtask

    // Count cycles until tick is seen (bounded), also counting done pulses on the way.
    task automatic run_until_tick(output int cyc, output int dones);
        cyc = 0;
        dones = 0;
        for (int i = 0; i < 50; i++) begin
            step();
            cyc++;
            if (done) dones++;
            if (tick) break;
        end
    endtask

    int cyc, dones, busy_hi, ticks;

    initial begin
        rst = 1'b1; load = 1'b0; load_sec = 7'd0; start = 1'b0; pause = 1'b0; abort = 1'b0;
        @(negedge clk);
        step();
        step();
        check("rst_state", int'(state), 0);
        check("rst_remaining", int'(remaining), 0);
        check("rst_tick", int'(tick), 0);
        check("rst_done", int'(done), 0);
        check("rst_busy", int'(busy), 0);
        rst = 1'b0;

        // Load and full countdown
        cmd(0, 1, 0, 0, 7'd3);
        check("load_remaining", int'(remaining), 3);
        check("load_state", int'(state), 0);
        check("load_busy", int'(busy), 0);
        cmd(0, 0, 0, 1, 7'd0);
        check("start_state", int'(state), 1);
        check("start_busy", int'(busy), 1);
        run_until_tick(cyc, dones);
        check("tick1_cycles", cyc, 4);
        check("tick1_remaining", int'(remaining), 2);
        check("tick1_no_done", dones, 0);
        run_until_tick(cyc, dones);
        check("tick2_cycles", cyc, 4);
        check("tick2_remaining", int'(remaining), 1);
        run_until_tick(cyc, dones);
        check("tick3_cycles", cyc, 4);
        check("tick3_remaining", int'(remaining), 0);
        check("tick3_done", int'(done), 1);
        check("tick3_done_count", dones, 1);
        check("tick3_state", int'(state), 3);
        check("tick3_busy", int'(busy), 0);
        step();
        check("done_pulse_end", int'(done), 0);
        check("done_tick_end", int'(tick), 0);
        cmd(0, 0, 0, 1, 7'd0);
        check("start_in_done", int'(state), 3);
        check("done_holds_zero", int'(remaining), 0);

        // Pause and resume preserve the partial second
        cmd(0, 1, 0, 0, 7'd2);
        cmd(0, 0, 0, 1, 7'd0);
        step();
        step();
        cmd(0, 0, 1, 0, 7'd0);
        check("pause_state", int'(state), 2);
        busy_hi = 0;
        ticks = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (busy) busy_hi++;
            if (tick) ticks++;
        end
        check("pause_busy_low", busy_hi, 0);
        check("pause_no_tick", ticks, 0);
        check("pause_remaining", int'(remaining), 2);
        cmd(0, 0, 0, 1, 7'd0);
        check("resume_state", int'(state), 1);
        run_until_tick(cyc, dones);
        check("resume_tick_cycles", cyc, 2);
        check("resume_remaining", int'(remaining), 1);

        // Priority
        cmd(0, 0, 1, 1, 7'd0);
        check("pause_over_start", int'(state), 2);
        cmd(1, 1, 0, 0, 7'd5);
        check("abort_over_load_state", int'(state), 0);
        check("abort_over_load_rem", int'(remaining), 0);

        // Boundaries
        cmd(0, 1, 0, 0, 7'd120);
        check("load_saturate", int'(remaining), 99);
        cmd(0, 1, 0, 0, 7'd0);
        cmd(0, 0, 0, 1, 7'd0);
        check("start_zero_idle", int'(state), 0);
        cmd(0, 1, 0, 0, 7'd3);
        cmd(0, 0, 0, 1, 7'd0);
        cmd(0, 1, 0, 0, 7'd7);
        check("load_in_run_rem", int'(remaining), 3);
        check("load_in_run_state", int'(state), 1);
        cmd(1, 0, 0, 0, 7'd0);
        check("abort_run_state", int'(state), 0);

        // Pause on the terminal edge
        cmd(0, 1, 0, 0, 7'd1);
        cmd(0, 0, 0, 1, 7'd0);
        step();
        step();
        step();
        cmd(0, 0, 1, 0, 7'd0);
        check("term_pause_state", int'(state), 2);
        check("term_pause_rem", int'(remaining), 1);
        check("term_pause_tick", int'(tick), 0);
        check("term_pause_done", int'(done), 0);
        cmd(0, 0, 0, 1, 7'd0);
        check("term_resume_state", int'(state), 1);
        check("term_resume_no_tick", int'(tick), 0);
        step();
        check("term_tick", int'(tick), 1);
        check("term_done", int'(done), 1);
        check("term_rem", int'(remaining), 0);
        check("term_state", int'(state), 3);

        // Abort on the terminal edge
        cmd(0, 1, 0, 0, 7'd1);
        cmd(0, 0, 0, 1, 7'd0);
        step();
        step();
        step();
        cmd(1, 0, 0, 0, 7'd0);
        check("term_abort_tick", int'(tick), 0);
        check("term_abort_done", int'(done), 0);
        check("term_abort_state", int'(state), 0);

        // Reset mid-count
        cmd(0, 1, 0, 0, 7'd2);
        cmd(0, 0, 0, 1, 7'd0);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst_state", int'(state), 0);
        check("midrst_rem", int'(remaining), 0);
        check("midrst_busy", int'(busy), 0);
        check("midrst_tick", int'(tick), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
